// File: rtl/nanov_spi_mem_ctrl.sv
// ============================================================================
// Module      : nanov_spi_mem_ctrl
// Description : SPI mode-0 memory controller (SCK = clk/2) issuing READ/WRITE
//               + address, streaming little-endian 32-bit words with backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nanov_spi_mem_ctrl #(
    parameter int          ADDR_BITS       = 24,
    parameter int          DESELECT_CYCLES = 2,
    parameter logic [7:0]  READ_CMD        = 8'h03,
    parameter logic [7:0]  WRITE_CMD       = 8'h02
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 is_write,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [31:0]          wdata,
    input  logic                 stop,
    output logic                 busy,
    output logic [31:0]          rdata,
    output logic                 rdata_valid,
    input  logic                 rdata_ready,
    output logic                 spi_select,
    output logic                 spi_clk_out,
    output logic                 spi_mosi,
    input  logic                 spi_miso
);

    localparam int TX_W  = 8 + ADDR_BITS + 32;
    localparam int CNT_W = $clog2(ADDR_BITS + 33) + 1;
    localparam int DS_W  = $clog2(DESELECT_CYCLES + 1) + 1;

    localparam logic [CNT_W-1:0] C_CMD_LAST  = CNT_W'(7);
    localparam logic [CNT_W-1:0] C_ADDR_LAST = CNT_W'(ADDR_BITS - 1);
    localparam logic [CNT_W-1:0] C_DATA_LAST = CNT_W'(31);
    localparam logic [DS_W-1:0]  C_DS_LAST   = DS_W'(DESELECT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CMD   = 3'd1,
        S_ADDR  = 3'd2,
        S_DATA  = 3'd3,
        S_STALL = 3'd4,
        S_DESEL = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic               sck_q, sck_d;
    logic               is_write_q, is_write_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DS_W-1:0]    ds_q, ds_d;
    logic [TX_W-1:0]    tx_q, tx_d;
    logic [31:0]        rx_q, rx_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               rvalid_q, rvalid_d;

    logic [31:0]        w_rx_next;
    logic [CNT_W-1:0]   w_phase_last;
    logic               w_shifting;
    logic               w_word_done;

    // First byte on the wire is bits [7:0]; each byte goes MSB first.
    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    always_comb begin
        state_d     = state_q;
        sck_d       = sck_q;
        is_write_d  = is_write_q;
        cnt_d       = cnt_q;
        ds_d        = ds_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        rdata_d     = rdata_q;
        rvalid_d    = rvalid_q;
        w_word_done = 1'b0;
        w_rx_next   = {rx_q[30:0], spi_miso};
        w_shifting  = (state_q == S_CMD) || (state_q == S_ADDR) || (state_q == S_DATA);

        case (state_q)
            S_CMD:   w_phase_last = C_CMD_LAST;
            S_ADDR:  w_phase_last = C_ADDR_LAST;
            default: w_phase_last = C_DATA_LAST;
        endcase

        if (rvalid_q && rdata_ready) begin
            rvalid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_CMD;
                    sck_d      = 1'b0;
                    cnt_d      = '0;
                    is_write_d = is_write;
                    tx_d       = {(is_write ? WRITE_CMD : READ_CMD), addr,
                                  (is_write ? bswap(wdata) : 32'h0)};
                end
            end
            S_CMD, S_ADDR, S_DATA: begin
                if (!sck_q) begin
                    // The low phase of a word's first bit is where a pending word blocks the stream.
                    if ((state_q == S_DATA) && (cnt_q == '0) && rvalid_q && !rdata_ready) begin
                        state_d = S_STALL;
                    end else begin
                        sck_d = 1'b1;
                    end
                end else begin
                    sck_d = 1'b0;
                    tx_d  = {tx_q[TX_W-2:0], 1'b0};
                    rx_d  = w_rx_next;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == w_phase_last) begin
                        cnt_d = '0;
                        if (state_q == S_CMD) begin
                            state_d = S_ADDR;
                        end else if (state_q == S_ADDR) begin
                            state_d = S_DATA;
                        end else if (is_write_q) begin
                            state_d = S_DESEL;
                            ds_d    = '0;
                        end else begin
                            w_word_done = 1'b1;
                        end
                    end
                end
            end
            S_STALL: begin
                // Stall cycles stand in for the low phase, so resume directly with SCK high.
                if (!rvalid_q || rdata_ready) begin
                    state_d = S_DATA;
                    sck_d   = 1'b1;
                end
            end
            S_DESEL: begin
                ds_d = ds_q + DS_W'(1);
                if (ds_q == C_DS_LAST) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (stop && !is_write_q && (w_shifting || (state_q == S_STALL))) begin
            state_d = S_DESEL;
            sck_d   = 1'b0;
            cnt_d   = '0;
            ds_d    = '0;
        end

        if (w_word_done) begin
            rdata_d  = bswap(w_rx_next);
            rvalid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            sck_q      <= 1'b0;
            is_write_q <= 1'b0;
            cnt_q      <= '0;
            ds_q       <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            sck_q      <= sck_d;
            is_write_q <= is_write_d;
            cnt_q      <= cnt_d;
            ds_q       <= ds_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign spi_select  = (state_q == S_IDLE) || (state_q == S_DESEL);
    assign spi_clk_out = sck_q;
    assign spi_mosi    = w_shifting && tx_q[TX_W-1];
    assign rdata       = rdata_q;
    assign rdata_valid = rvalid_q;

endmodule

`default_nettype wire

// File: tb/tb_nanov_spi_mem_ctrl.sv
// ============================================================================
// Module      : tb_nanov_spi_mem_ctrl
// Description : Scoreboard bench for nanov_spi_mem_ctrl with an SPI RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nanov_spi_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        is_write = 1'b0;
    logic [23:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        stop = 1'b0;
    logic        busy;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        rdata_ready = 1'b1;
    logic        spi_select;
    logic        spi_clk_out;
    logic        spi_mosi;
    logic        spi_miso = 1'b0;

    nanov_spi_mem_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .is_write    (is_write),
        .addr        (addr),
        .wdata       (wdata),
        .stop        (stop),
        .busy        (busy),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .rdata_ready (rdata_ready),
        .spi_select  (spi_select),
        .spi_clk_out (spi_clk_out),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int t0  = 0;
    always @(posedge clk) cyc = cyc + 1;

    int applied = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] data;
        int          vcyc;
    } exp_t;
    exp_t exp_q[$];

    // ---------------- SPI memory model ----------------
    logic [7:0]  mem [0:1023];
    logic [7:0]  mosi_bytes[$];
    int          bitcnt = 0;
    logic [7:0]  sh = '0;
    logic [7:0]  mcmd = '0;
    logic [23:0] maddr = '0;
    int          mosi_nz = 0;

    always @(negedge clk) begin
        int n;
        logic [7:0] b;
        if (spi_select) begin
            bitcnt = 0;
        end else if (spi_clk_out) begin
            sh = {sh[6:0], spi_mosi};
            if (mcmd == 8'h03 && bitcnt >= 32 && spi_mosi) mosi_nz++;
            bitcnt++;
            if (bitcnt % 8 == 0) begin
                if (bitcnt == 8) mcmd = sh;
                else if (bitcnt <= 32) maddr = {maddr[15:0], sh};
                if (bitcnt <= 32 || (mcmd == 8'h02 && bitcnt <= 64)) mosi_bytes.push_back(sh);
                if (mcmd == 8'h02 && bitcnt > 32 && bitcnt <= 64)
                    mem[(maddr + 24'((bitcnt - 33) / 8)) & 24'h3FF] = sh;
            end
        end else begin
            if (bitcnt >= 32) begin
                n = bitcnt - 32;
                b = mem[(maddr + 24'(n / 8)) & 24'h3FF];
                spi_miso = b[7 - (n % 8)];
            end else begin
                spi_miso = 1'b0;
            end
        end
    end

    int   sck_rises = 0;
    int   sel_falls = 0;
    logic prev_sck = 1'b0;
    logic prev_sel = 1'b1;
    always @(negedge clk) begin
        if (spi_clk_out && !prev_sck) sck_rises++;
        if (!spi_select && prev_sel) sel_falls++;
        prev_sck = spi_clk_out;
        prev_sel = spi_select;
    end

    // ---------------- scoreboard monitor ----------------
    logic prev_valid = 1'b0;
    int   rise_cyc = -1;
    always @(negedge clk) begin
        exp_t e;
        if (rdata_valid && !prev_valid) rise_cyc = cyc - t0;
        prev_valid = rdata_valid;
        if (rdata_valid && rdata_ready) begin
            applied++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_word: got %08h required none", rdata);
            end else begin
                e = exp_q.pop_front();
                if (rdata !== e.data) begin
                    miscompares++;
                    $display("FAIL rdata: got %08h required %08h", rdata, e.data);
                end
                if (e.vcyc >= 0) begin
                    applied++;
                    if (rise_cyc != e.vcyc) begin
                        miscompares++;
                        $display("FAIL valid_cycle: got %0d required %0d", rise_cyc, e.vcyc);
                    end
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
        applied++;
        if (got !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h required %0h", name, got, req);
        end
    endtask

    task automatic goto_cyc(input int k);
        while (cyc - t0 < k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start(input logic w, input logic [23:0] a, input logic [31:0] d);
        is_write = w;
        addr     = a;
        wdata    = d;
        mosi_bytes.delete();
        mosi_nz  = 0;
        start    = 1'b1;
        t0       = cyc;
        @(posedge clk);
        #1;
        start    = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("idle_timeout", 64'(busy), 64'd0);
    endtask

    task automatic push_exp(input logic [31:0] d, input int vc);
        exp_t e;
        e.data = d;
        e.vcyc = vc;
        exp_q.push_back(e);
    endtask

    task automatic chk_mosi(input logic [7:0] ex [8], input int nb);
        chk("mosi_count", 64'(mosi_bytes.size()), 64'(nb));
        for (int i = 0; i < nb && i < mosi_bytes.size(); i++)
            chk($sformatf("mosi_byte%0d", i), 64'(mosi_bytes[i]), 64'(ex[i]));
    endtask

    initial begin
        logic [7:0] ex [8];
        int bad;

        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        for (int i = 0; i < 12; i++) mem[256 + i] = 8'(8'h11 * (i + 1));
        for (int i = 0; i < 8; i++) mem[512 + i] = 8'(8'hA0 + i);

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_select", 64'(spi_select), 64'd1);
        chk("rst_sck", 64'(spi_clk_out), 64'd0);
        chk("rst_mosi", 64'(spi_mosi), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_valid", 64'(rdata_valid), 64'd0);
        chk("rst_rdata", 64'(rdata), 64'd0);
        @(posedge clk);
        #1;

        // Streamed read, ready always high, stop after the third word
        rdata_ready = 1'b1;
        push_exp(32'h44332211, 129);
        push_exp(32'h88776655, 193);
        push_exp(32'hCCBBAA99, 257);
        do_start(1'b0, 24'h000100, 32'h0);
        chk("start_select", 64'(spi_select), 64'd0);
        chk("start_busy", 64'(busy), 64'd1);
        goto_cyc(257);
        stop = 1'b1;
        goto_cyc(258);
        stop = 1'b0;
        chk("stop_select", 64'(spi_select), 64'd1);
        chk("stop_sck", 64'(spi_clk_out), 64'd0);
        ex = '{8'h03, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        chk_mosi(ex, 4);
        chk("read_mosi_zero", 64'(mosi_nz), 64'd0);
        wait_idle();
        repeat (3) @(posedge clk);
        #1;

        // Backpressure: word 1 held for 40 cycles
        rdata_ready = 1'b0;
        push_exp(32'hA3A2A1A0, 129);
        push_exp(32'hA7A6A5A4, 233);
        do_start(1'b0, 24'h000200, 32'h0);
        bad = 0;
        for (int k = 130; k < 169; k++) begin
            goto_cyc(k);
            if (spi_clk_out || spi_select || !rdata_valid) bad++;
        end
        chk("stall_frozen", 64'(bad), 64'd0);
        goto_cyc(169);
        rdata_ready = 1'b1;
        goto_cyc(233);
        stop = 1'b1;
        goto_cyc(234);
        stop = 1'b0;
        ex = '{8'h03, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        chk_mosi(ex, 4);
        wait_idle();
        repeat (3) @(posedge clk);
        #1;

        // Write with stray start/stop pulses that must be ignored
        sck_rises = 0;
        sel_falls = 0;
        do_start(1'b1, 24'h0000FC, 32'hDEADBEEF);
        goto_cyc(40);  start = 1'b1;
        goto_cyc(41);  start = 1'b0;
        goto_cyc(60);  stop = 1'b1;
        goto_cyc(61);  stop = 1'b0;
        goto_cyc(129);
        chk("wr_desel_select", 64'(spi_select), 64'd1);
        start = 1'b1;
        goto_cyc(130);
        start = 1'b0;
        chk("wr_busy_130", 64'(busy), 64'd1);
        goto_cyc(131);
        chk("wr_busy_131", 64'(busy), 64'd0);
        goto_cyc(160);
        chk("wr_sck_rises", 64'(sck_rises), 64'd64);
        chk("wr_sel_falls", 64'(sel_falls), 64'd1);
        ex = '{8'h02, 8'h00, 8'h00, 8'hFC, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        chk_mosi(ex, 8);
        chk("wr_mem", 64'({mem[255], mem[254], mem[253], mem[252]}), 64'hDEADBEEF);

        // Reset in the middle of a read, then a fresh read
        do_start(1'b0, 24'h000100, 32'h0);
        goto_cyc(50);
        rst = 1'b1;
        goto_cyc(51);
        rst = 1'b0;
        chk("mid_rst_select", 64'(spi_select), 64'd1);
        chk("mid_rst_sck", 64'(spi_clk_out), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_valid", 64'(rdata_valid), 64'd0);
        @(posedge clk);
        #1;
        push_exp(32'h44332211, 129);
        do_start(1'b0, 24'h000100, 32'h0);
        goto_cyc(129);
        stop = 1'b1;
        goto_cyc(130);
        stop = 1'b0;
        wait_idle();
        repeat (10) @(posedge clk);
        #1;

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout required finish");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
